wired_cdb_arbiter: RTL and testbench
====================================

Name: wired_cdb_arbiter

Overview:
- Collects completed results from the functional-unit issue queues and drives the two CDB broadcast ports seen by the dispatch stage, the ROB and every IQ snoop port.
- Sources are LSU, MDU and ALU. Each source has 2 result lanes with a valid/ready handshake.
- Fixed-priority arbitration (LSU > MDU > ALU) picks up to 2 winners per cycle. Winners are registered onto the CDB with 1-cycle latency.

Parameters:
- N_SRC, 3, number of functional-unit sources. Index 0 = LSU, 1 = MDU, 2 = ALU. Lower index has higher priority.
- N_LANE, 2, result lanes per source.
- N_CDB, 2, CDB broadcast ports. Fixed at 2; elaboration error otherwise.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- fu_payload_i  in  [N_SRC][N_LANE] pipeline_cdb_t  per-lane result payload
- fu_valid_i  in  [N_SRC][N_LANE]  lane holds a result
- fu_ready_o  out  [N_SRC][N_LANE]  lane result accepted this cycle
- cdb_o  out  [N_CDB] pipeline_cdb_t  registered CDB broadcast payload
- cdb_valid_o  out  [N_CDB]  registered CDB broadcast valid
- flush_i  in  1  backend flush; drop in-flight results

Behaviour:
- Reset: cdb_valid_o = 0, cdb_o = 0, fu_ready_o = 0 while rst is high. Asserting rst mid-transfer discards everything.
- Request vector r[5:0] = {alu1, alu0, mdu1, mdu0, lsu1, lsu0}. Bit 0 (lsu0) is the highest priority.
- Grant: g0 = lowest set bit of r. g1 = lowest set bit of r & ~g0.
- Output assignment: g0 is registered into cdb port 0 and g1 into cdb port 1.
  - Only one request present: port 1 valid = 0 and port 1 payload holds its previous value.
  - No request present: both valid = 0.
- fu_ready_o = g0 | g1, combinational from fu_valid_i. No combinational path from any other input except flush_i.
- A transfer happens when valid & ready, and it is final: the lane must present its next result or deassert valid in the next cycle.
- A lane not granted keeps valid and payload stable. Ungranted sources may starve under sustained higher-priority traffic; this is accepted by design.
- Latency: a result granted in cycle t appears on cdb_o/cdb_valid_o in cycle t+1 for exactly 1 cycle. The CDB has no backpressure.
- Throughput: 2 results/cycle when at least 2 lanes are valid.
- Flush:
  - While flush_i = 1, fu_ready_o = all ones, so every valid lane is drained and dropped.
  - cdb_valid_o registers 0 on the next edge.
  - Results already on cdb_o in the flush cycle are still presented that cycle.
- Same-cycle tie-break: the two lanes of one source are ordered lane0 before lane1. Both lanes of one source may win together.

Optional Feature:
- Macro: WIRED_CDB_SKID_EN.
- Enabled:
  - Each lane gets a 1-entry skid register.
  - fu_ready_o = skid empty, a registered signal with no combinational valid-to-ready path.
  - Arbitration runs on skid contents. A skid entry is freed when granted, and can refill in that same cycle.
  - Latency from fu_valid_i to cdb_valid_o becomes 2 cycles.
  - Flush empties all skids on the next edge.
  - Reset empties skids; fu_ready_o = 1 after reset deasserts.
- Disabled: behaviour exactly as above, 1-cycle latency, combinational ready.

Decomposition:
- pipeline_cdb_t and the source index constants (CDB_SRC_LSU = 0, CDB_SRC_MDU = 1, CDB_SRC_ALU = 2) live in the shared wired package, alongside the existing one-hot helper macros.
- Sub-module wired_cdb_skid: the 1-entry per-lane skid buffer, instantiated N_SRC*N_LANE times only under WIRED_CDB_SKID_EN.
- The grant logic reuses the one-hot leading-one macro twice, masking the first grant before the second search.

Test Plan:
- Reset: hold rst for 3 cycles with all lanes valid -> cdb_valid_o = 00 and fu_ready_o = 0 throughout. First grants appear on the edge after rst falls (default build).
- All 6 lanes valid, alu0 tag 0x15, lsu0 tag 0x01, lsu1 tag 0x02:
  - Ready asserts only on lsu0 and lsu1.
  - Next cycle cdb_o[0].tag = 0x01, cdb_o[1].tag = 0x02, cdb_valid_o = 11.
  - ALU ready stays 0 while LSU remains valid.
- Single request, only mdu1 valid with tag 0x0A -> its ready = 1. Next cycle cdb_valid_o = 01 and cdb_o[0].tag = 0x0A.
- Mixed sources, lsu1 and alu0 valid -> both granted. Next cycle port 0 carries lsu1 and port 1 carries alu0.
- Flush: 4 lanes valid with flush_i = 1 for 1 cycle -> all 4 ready = 1 and the next cycle cdb_valid_o = 00. A result registered in the prior cycle is still visible during the flush cycle.
- Skid build with all lanes valid for 4 cycles:
  - Ready is high in the first cycle only, then drops for skids not granted.
  - Results reach the CDB 2 cycles after acceptance in priority order, 2 per cycle.
  - Ready is never combinationally dependent on fu_valid_i (checked by assertion).

Source files
------------

// File: rtl/wired_cdb_arbiter_pkg.sv
// Shared CDB payload type, source indices and one-hot helper macros for the wired backend.
`ifndef WIRED_CDB_ARBITER_PKG_SV
`define WIRED_CDB_ARBITER_PKG_SV

// Isolates the lowest set bit, i.e. the highest-priority requester in an index-ordered vector.
`define WIRED_ONEHOT_FIRST(x) ((x) & (-(x)))

package wired_cdb_arbiter_pkg;

    localparam int unsigned TAG_W  = 7;
    localparam int unsigned DATA_W = 32;

    localparam int unsigned CDB_N_SRC  = 3;
    localparam int unsigned CDB_N_LANE = 2;
    localparam int unsigned CDB_N_CDB  = 2;

    localparam int unsigned CDB_SRC_LSU = 0;
    localparam int unsigned CDB_SRC_MDU = 1;
    localparam int unsigned CDB_SRC_ALU = 2;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              exc;
    } pipeline_cdb_t;

endpackage

`endif

// File: rtl/wired_cdb_skid.sv
// One-entry per-lane skid register, used only when WIRED_CDB_SKID_EN is defined.
// An entry being granted this cycle may be replaced by a new result on the same edge.
module wired_cdb_skid
    import wired_cdb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    input  pipeline_cdb_t in_payload_i,
    input  logic          grant_i,
    output logic          empty_o,
    output logic          out_valid_o,
    output pipeline_cdb_t out_payload_o
);
    logic          valid_d, valid_q;
    pipeline_cdb_t payload_d, payload_q;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (grant_i) begin
            valid_d = 1'b0;
        end
        if (in_valid_i && (!valid_q || grant_i)) begin
            valid_d   = 1'b1;
            payload_d = in_payload_i;
        end
        // Flush wins over a same-cycle refill: that result is in flight and gets dropped.
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign empty_o       = ~valid_q;
    assign out_valid_o   = valid_q;
    assign out_payload_o = payload_q;

endmodule

// File: rtl/wired_cdb_arbiter.sv
// CDB arbiter: fixed-priority (LSU > MDU > ALU, lane0 > lane1) pick of up to two results per cycle.
// Define WIRED_CDB_SKID_EN to put a skid on every lane for a registered ready (2-cycle latency).
module wired_cdb_arbiter
    import wired_cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC  = CDB_N_SRC,
    parameter int unsigned N_LANE = CDB_N_LANE,
    parameter int unsigned N_CDB  = CDB_N_CDB
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  pipeline_cdb_t [N_SRC-1:0][N_LANE-1:0] fu_payload_i,
    input  logic          [N_SRC-1:0][N_LANE-1:0] fu_valid_i,
    output logic          [N_SRC-1:0][N_LANE-1:0] fu_ready_o,
    output pipeline_cdb_t [N_CDB-1:0]             cdb_o,
    output logic          [N_CDB-1:0]             cdb_valid_o,
    input  logic                                  flush_i
);
    localparam int unsigned N_REQ = N_SRC * N_LANE;

    if (N_CDB != 2) begin : g_bad_n_cdb
        $error("wired_cdb_arbiter: N_CDB must be 2");
    end

    logic          [N_REQ-1:0] lane_valid;
    pipeline_cdb_t [N_REQ-1:0] lane_payload;
    logic          [N_REQ-1:0] gnt0;
    logic          [N_REQ-1:0] gnt1;
    logic          [N_REQ-1:0] gnt_any;
    pipeline_cdb_t             sel0;
    pipeline_cdb_t             sel1;
    logic          [1:0]       cdb_valid_d, cdb_valid_q;
    pipeline_cdb_t [1:0]       cdb_d, cdb_q;

`ifdef WIRED_CDB_SKID_EN
    logic [N_REQ-1:0] skid_empty;

    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        for (genvar l = 0; l < N_LANE; l++) begin : g_lane
            localparam int unsigned IDX = s * N_LANE + l;
            wired_cdb_skid u_skid (
                .clk          (clk),
                .rst          (rst),
                .flush_i      (flush_i),
                .in_valid_i   (fu_valid_i[s][l]),
                .in_payload_i (fu_payload_i[s][l]),
                .grant_i      (gnt_any[IDX]),
                .empty_o      (skid_empty[IDX]),
                .out_valid_o  (lane_valid[IDX]),
                .out_payload_o(lane_payload[IDX])
            );
        end
    end

    // Grants come from skid state only, so ready never depends on fu_valid_i.
    assign fu_ready_o = rst ? '0 : (skid_empty | gnt_any);
`else
    assign lane_valid   = fu_valid_i;
    assign lane_payload = fu_payload_i;
    assign fu_ready_o   = rst ? '0 : (flush_i ? '1 : gnt_any);
`endif

    // Second winner is the first requester left once the first winner is masked off.
    always_comb begin
        gnt0    = `WIRED_ONEHOT_FIRST(lane_valid);
        gnt1    = `WIRED_ONEHOT_FIRST(lane_valid & ~gnt0);
        gnt_any = gnt0 | gnt1;
        sel0    = '0;
        sel1    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt0[i]) sel0 = lane_payload[i];
            if (gnt1[i]) sel1 = lane_payload[i];
        end
    end

    // A port with no winner keeps its previous payload; only its valid drops.
    always_comb begin
        cdb_valid_d = '0;
        cdb_d       = cdb_q;
        if (!flush_i) begin
            cdb_valid_d = {|gnt1, |gnt0};
            if (|gnt0) cdb_d[0] = sel0;
            if (|gnt1) cdb_d[1] = sel1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q <= '0;
            cdb_q       <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
        end
    end

    assign cdb_o       = cdb_q;
    assign cdb_valid_o = cdb_valid_q;

endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Bench for wired_cdb_arbiter: priority-list model checked every cycle plus directed literal checks.
// Define WIRED_CDB_SKID_EN for the skid-buffered variant.
module tb_wired_cdb_arbiter;
    import wired_cdb_arbiter_pkg::*;

    localparam int unsigned NL = CDB_N_SRC * CDB_N_LANE;
    localparam int LSU0 = CDB_SRC_LSU * 2;
    localparam int LSU1 = CDB_SRC_LSU * 2 + 1;
    localparam int MDU0 = CDB_SRC_MDU * 2;
    localparam int MDU1 = CDB_SRC_MDU * 2 + 1;
    localparam int ALU0 = CDB_SRC_ALU * 2;
    localparam int ALU1 = CDB_SRC_ALU * 2 + 1;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic          [NL-1:0] vld;
    pipeline_cdb_t [NL-1:0] pay;
    logic          [CDB_N_SRC-1:0][CDB_N_LANE-1:0] fu_valid;
    logic          [CDB_N_SRC-1:0][CDB_N_LANE-1:0] fu_ready;
    pipeline_cdb_t [CDB_N_SRC-1:0][CDB_N_LANE-1:0] fu_payload;
    pipeline_cdb_t [1:0] cdb;
    logic          [1:0] cdb_valid;

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_en = 1'b0;

    assign fu_valid   = vld;
    assign fu_payload = pay;

    always #5 clk = ~clk;

    wired_cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .fu_payload_i(fu_payload),
        .fu_valid_i  (fu_valid),
        .fu_ready_o  (fu_ready),
        .cdb_o       (cdb),
        .cdb_valid_o (cdb_valid),
        .flush_i     (flush)
    );

    // Model state: what the CDB must show, and (skid build) what each lane is holding.
    logic [1:0]    m_v = '0;
    pipeline_cdb_t m_cdb [2] = '{default: '0};
`ifdef WIRED_CDB_SKID_EN
    logic [NL-1:0] m_sv = '0;
    pipeline_cdb_t m_sp [NL] = '{default: '0};
`endif

    // Lanes are listed in priority order, so the winners are simply the first two holders.
    function automatic logic [NL-1:0] first_two(input logic [NL-1:0] v);
        logic [NL-1:0] w;
        int n;
        w = '0;
        n = 0;
        for (int i = 0; i < NL; i++) begin
            if (v[i] && n < 2) begin
                w[i] = 1'b1;
                n++;
            end
        end
        return w;
    endfunction

    function automatic logic [NL-1:0] model_ready();
`ifdef WIRED_CDB_SKID_EN
        return rst ? '0 : (~m_sv | first_two(m_sv));
`else
        return rst ? '0 : (flush ? '1 : first_two(vld));
`endif
    endfunction

    always @(posedge clk) begin
        logic [NL-1:0] src_v;
        logic [NL-1:0] rdy;
        pipeline_cdb_t src_p [NL];
        int k;
        rdy = model_ready();
`ifdef WIRED_CDB_SKID_EN
        src_v = m_sv;
        for (int i = 0; i < NL; i++) src_p[i] = m_sp[i];
`else
        src_v = vld;
        for (int i = 0; i < NL; i++) src_p[i] = pay[i];
`endif
        if (rst) begin
            m_v      = '0;
            m_cdb[0] = '0;
            m_cdb[1] = '0;
`ifdef WIRED_CDB_SKID_EN
            m_sv     = '0;
`endif
        end else if (flush) begin
            m_v = '0;
`ifdef WIRED_CDB_SKID_EN
            m_sv = '0;
`endif
        end else begin
            m_v = '0;
            k   = 0;
            for (int i = 0; i < NL; i++) begin
                if (src_v[i] && k < 2) begin
                    m_cdb[k] = src_p[i];
                    m_v[k]   = 1'b1;
`ifdef WIRED_CDB_SKID_EN
                    m_sv[i]  = 1'b0;
`endif
                    k++;
                end
            end
`ifdef WIRED_CDB_SKID_EN
            for (int i = 0; i < NL; i++) begin
                if (vld[i] && rdy[i]) begin
                    m_sv[i] = 1'b1;
                    m_sp[i] = pay[i];
                end
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_ready", 64'(fu_ready), 64'(model_ready()));
            chk("model_cdb_valid", 64'(cdb_valid), rst ? 64'd0 : 64'(m_v));
            chk("model_cdb0", 64'(cdb[0]), rst ? 64'd0 : 64'(m_cdb[0]));
            chk("model_cdb1", 64'(cdb[1]), rst ? 64'd0 : 64'(m_cdb[1]));
        end
    end

    function automatic pipeline_cdb_t mk(input logic [TAG_W-1:0] tag);
        pipeline_cdb_t r;
        r.tag  = tag;
        r.data = 32'hC0DE_0000 | 32'(tag);
        r.exc  = tag[0];
        return r;
    endfunction

    task automatic lane(input int i, input logic v, input logic [TAG_W-1:0] tag);
        vld[i] = v;
        pay[i] = mk(tag);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        vld   = '0;
        pay   = '0;
        #1 rst = 1'b1;
        lane(LSU0, 1'b1, 7'h01); lane(LSU1, 1'b1, 7'h02);
        lane(MDU0, 1'b1, 7'h0B); lane(MDU1, 1'b1, 7'h0C);
        lane(ALU0, 1'b1, 7'h15); lane(ALU1, 1'b1, 7'h16);
        cmp_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("rst_ready", 64'(fu_ready), 64'h0);
            chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
            next_cycle();
        end
        rst = 1'b0;
        chk("post_rst_cdb_valid", 64'(cdb_valid), 64'h0);

`ifndef WIRED_CDB_SKID_EN
        mid();
        chk("all6_ready", 64'(fu_ready), 64'b000011);
        next_cycle();
        chk("all6_valid", 64'(cdb_valid), 64'b11);
        chk("all6_tag0", 64'(cdb[0].tag), 64'h01);
        chk("all6_tag1", 64'(cdb[1].tag), 64'h02);
        lane(LSU0, 1'b1, 7'h03); lane(LSU1, 1'b1, 7'h04);
        mid();
        chk("alu_starved_ready", 64'(fu_ready), 64'b000011);
        next_cycle();
        chk("lsu2_tag0", 64'(cdb[0].tag), 64'h03);
        chk("lsu2_tag1", 64'(cdb[1].tag), 64'h04);
        lane(LSU0, 1'b0, 7'h00); lane(LSU1, 1'b0, 7'h00);
        mid();
        chk("mdu_ready", 64'(fu_ready), 64'b001100);
        next_cycle();
        chk("mdu_tag0", 64'(cdb[0].tag), 64'h0B);
        chk("mdu_tag1", 64'(cdb[1].tag), 64'h0C);
        lane(MDU0, 1'b0, 7'h00); lane(MDU1, 1'b0, 7'h00);
        mid();
        chk("alu_ready", 64'(fu_ready), 64'b110000);
        next_cycle();
        chk("alu_tag0", 64'(cdb[0].tag), 64'h15);
        chk("alu_tag1", 64'(cdb[1].tag), 64'h16);

        vld = '0;
        lane(MDU1, 1'b1, 7'h0A);
        mid();
        chk("single_ready", 64'(fu_ready), 64'b001000);
        next_cycle();
        chk("single_valid", 64'(cdb_valid), 64'b01);
        chk("single_tag0", 64'(cdb[0].tag), 64'h0A);
        chk("single_port1_hold", 64'(cdb[1].tag), 64'h16);

        vld = '0;
        lane(LSU1, 1'b1, 7'h22); lane(ALU0, 1'b1, 7'h25);
        mid();
        chk("mixed_ready", 64'(fu_ready), 64'b010010);
        next_cycle();
        chk("mixed_valid", 64'(cdb_valid), 64'b11);
        chk("mixed_tag0", 64'(cdb[0].tag), 64'h22);
        chk("mixed_tag1", 64'(cdb[1].tag), 64'h25);

        vld = '0;
        mid();
        chk("idle_ready", 64'(fu_ready), 64'h0);
        next_cycle();
        chk("idle_valid", 64'(cdb_valid), 64'b00);

        lane(MDU0, 1'b1, 7'h31);
        mid();
        chk("preflush_ready", 64'(fu_ready), 64'b000100);
        next_cycle();
        vld = '0;
        lane(LSU0, 1'b1, 7'h41); lane(MDU1, 1'b1, 7'h42);
        lane(ALU0, 1'b1, 7'h43); lane(ALU1, 1'b1, 7'h44);
        flush = 1'b1;
        chk("flush_cycle_valid", 64'(cdb_valid), 64'b01);
        chk("flush_cycle_tag0", 64'(cdb[0].tag), 64'h31);
        mid();
        chk("flush_ready", 64'(fu_ready), 64'b111111);
        next_cycle();
        flush = 1'b0;
        vld   = '0;
        chk("post_flush_valid", 64'(cdb_valid), 64'b00);
        lane(ALU1, 1'b1, 7'h50);
        mid();
        chk("recover_ready", 64'(fu_ready), 64'b100000);
        next_cycle();
        chk("recover_valid", 64'(cdb_valid), 64'b01);
        chk("recover_tag0", 64'(cdb[0].tag), 64'h50);
        vld = '0;
`else
        mid();
        chk("skid_ready_after_rst", 64'(fu_ready), 64'b111111);
        for (int c = 0; c < 4; c++) begin
            logic [NL-1:0] acc;
            if (c > 0) mid();
            if (c == 1) begin
                chk("skid_ready_full", 64'(fu_ready), 64'b000011);
                chk("skid_latency_valid", 64'(cdb_valid), 64'b00);
                vld = '0;
                #1;
                chk("skid_ready_no_valid_path", 64'(fu_ready), 64'b000011);
                vld = '1;
                #1;
            end
            acc = vld & model_ready();
            next_cycle();
            for (int i = 0; i < NL; i++) begin
                if (acc[i]) pay[i] = mk(7'(pay[i].tag + 7'd1));
            end
            if (c == 1) begin
                chk("skid_c3_valid", 64'(cdb_valid), 64'b11);
                chk("skid_c3_tag0", 64'(cdb[0].tag), 64'h01);
                chk("skid_c3_tag1", 64'(cdb[1].tag), 64'h02);
            end
            if (c == 2) begin
                chk("skid_c4_tag0", 64'(cdb[0].tag), 64'h02);
                chk("skid_c4_tag1", 64'(cdb[1].tag), 64'h03);
            end
        end
        vld = '0;
        repeat (6) next_cycle();
        mid();
        chk("skid_drained_ready", 64'(fu_ready), 64'b111111);
        next_cycle();
        vld = '1;
        next_cycle();
        vld   = '0;
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        chk("skid_flush_valid", 64'(cdb_valid), 64'b00);
        mid();
        chk("skid_flush_empty", 64'(fu_ready), 64'b111111);
        next_cycle();
        chk("skid_post_flush_valid", 64'(cdb_valid), 64'b00);
`endif

        for (int p = 0; p < 6; p++) begin
            logic [NL-1:0] masks [6];
            masks = '{6'b101010, 6'b010101, 6'b100001, 6'b111100, 6'b000000, 6'b011000};
            for (int i = 0; i < NL; i++) lane(i, masks[p][i], 7'(8'h60 + 8'(p * 8 + i)));
            next_cycle();
        end

        vld = '1;
        repeat (2) next_cycle();
        rst = 1'b1;
        #1;
        chk("midrst_cdb_valid", 64'(cdb_valid), 64'b00);
        chk("midrst_ready", 64'(fu_ready), 64'h0);
        chk("midrst_cdb0", 64'(cdb[0]), 64'h0);
        next_cycle();
        rst = 1'b0;
        vld = '0;
        next_cycle();
        chk("midrst_discarded", 64'(cdb_valid), 64'b00);
        repeat (3) next_cycle();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
